train_sensor_frontend: RTL and testbench

Track-side sensor front-end that produces the per-crossing `train_detected` / `train_exited` pulses and `sensor_health` flags consumed by the crossing controller. For each crossing it:
- synchronises and debounces an approach and an exit axle sensor;
- keeps a net axle count and runs a small occupancy state machine;
- flags counting or sensor faults.

It sits between the raw track I/O and the crossing controller, one instance for all crossings.

---
 rtl/railway_pkg.sv | 20 ++
 rtl/sensor_debounce.sv | 53 +++++
 rtl/train_sensor_frontend.sv | 159 +++++++++++++++
 tb/tb_train_sensor_frontend.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/railway_pkg.sv
// Shared encodings for the track-side sensor front-end: occupancy states and fault causes.
package railway_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned CAUSE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    OccClear    = 2'd0,
    OccOccupied = 2'd1,
    OccFault    = 2'd2
  } occ_state_t;

  localparam logic [CAUSE_W-1:0] FC_NONE           = 3'd0;
  localparam logic [CAUSE_W-1:0] FC_UNDERFLOW      = 3'd1;
  localparam logic [CAUSE_W-1:0] FC_OVERFLOW       = 3'd2;
  localparam logic [CAUSE_W-1:0] FC_TIMEOUT        = 3'd3;
  localparam logic [CAUSE_W-1:0] FC_STUCK_APPROACH = 3'd4;
  localparam logic [CAUSE_W-1:0] FC_STUCK_EXIT     = 3'd5;

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser, counting debouncer and registered rising-edge pulse for one sensor.
module sensor_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive samples that disagree with the held level; any agreeing sample restarts.
  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/train_sensor_frontend.sv
// Per-crossing axle counting, occupancy FSM, occupancy/stuck timers and fault latching.
module train_sensor_frontend
  import railway_pkg::*;
#(
  parameter int unsigned NUM_CROSSINGS   = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned AXLE_CNT_W      = 8,
  parameter logic [23:0] TIMEOUT_CYCLES  = 24'd10_000_000,
  parameter logic [23:0] STUCK_CYCLES    = 24'd5_000_000
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_CROSSINGS-1:0]            approach_raw,
  input  logic [NUM_CROSSINGS-1:0]            exit_raw,
  input  logic [NUM_CROSSINGS-1:0]            fault_clear,
  output logic [NUM_CROSSINGS-1:0]            train_detected,
  output logic [NUM_CROSSINGS-1:0]            train_exited,
  output logic [NUM_CROSSINGS-1:0]            sensor_health,
  output logic [NUM_CROSSINGS*STATE_W-1:0]    occ_states,
  output logic [NUM_CROSSINGS*AXLE_CNT_W-1:0] axle_counts,
  output logic [NUM_CROSSINGS*CAUSE_W-1:0]    fault_causes
);

  logic [NUM_CROSSINGS-1:0] app_level, app_rise, exit_level, exit_rise;

  for (genvar j = 0; j < NUM_CROSSINGS; j++) begin : g_xing
    sensor_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_app_db (
      .clk  (clk),
      .rst  (rst),
      .raw  (approach_raw[j]),
      .level(app_level[j]),
      .rise (app_rise[j])
    );

    sensor_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_exit_db (
      .clk  (clk),
      .rst  (rst),
      .raw  (exit_raw[j]),
      .level(exit_level[j]),
      .rise (exit_rise[j])
    );

    occ_state_t             state_q, state_d;
    logic [AXLE_CNT_W-1:0]  count_q, count_d;
    logic [CAUSE_W-1:0]     cause_q, cause_d;
    logic [23:0]            occ_tmr_q, occ_tmr_d;
    logic [23:0]            stuck_app_q, stuck_app_d;
    logic [23:0]            stuck_exit_q, stuck_exit_d;
    logic                   det_q, det_d;
    logic                   exited_q, exited_d;
    logic                   app_e, exit_e, any_e, both_e;
    logic [CAUSE_W-1:0]     fault;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q      <= OccClear;
        count_q      <= '0;
        cause_q      <= FC_NONE;
        occ_tmr_q    <= '0;
        stuck_app_q  <= '0;
        stuck_exit_q <= '0;
        det_q        <= 1'b0;
        exited_q     <= 1'b0;
      end else begin
        state_q      <= state_d;
        count_q      <= count_d;
        cause_q      <= cause_d;
        occ_tmr_q    <= occ_tmr_d;
        stuck_app_q  <= stuck_app_d;
        stuck_exit_q <= stuck_exit_d;
        det_q        <= det_d;
        exited_q     <= exited_d;
      end
    end

    always_comb begin
      app_e   = app_rise[j];
      exit_e  = exit_rise[j];
      any_e   = app_e | exit_e;
      both_e  = app_e & exit_e;
      state_d = state_q;
      count_d = count_q;
      cause_d = cause_q;
      fault   = FC_NONE;
      occ_tmr_d    = '0;
      stuck_app_d  = (state_q != OccFault && app_level[j])  ? stuck_app_q + 24'd1  : '0;
      stuck_exit_d = (state_q != OccFault && exit_level[j]) ? stuck_exit_q + 24'd1 : '0;

      case (state_q)
        OccClear: begin
          if (!both_e) begin
            if (app_e) begin
              state_d = OccOccupied;
              count_d = AXLE_CNT_W'(1);
            end else if (exit_e) begin
              fault = FC_UNDERFLOW;
            end
          end
        end
        OccOccupied: begin
          if (!any_e) occ_tmr_d = occ_tmr_q + 24'd1;
          if (!both_e) begin
            if (app_e) begin
              if (&count_q) fault = FC_OVERFLOW;
              else          count_d = count_q + AXLE_CNT_W'(1);
            end else if (exit_e) begin
              count_d = count_q - AXLE_CNT_W'(1);
              if (count_q == AXLE_CNT_W'(1)) state_d = OccClear;
            end
          end
          if (fault == FC_NONE && !any_e && occ_tmr_q == TIMEOUT_CYCLES - 24'd1) begin
            fault = FC_TIMEOUT;
          end
        end
        OccFault: begin
          if (fault_clear[j] && !app_level[j] && !exit_level[j]) begin
            state_d = OccClear;
            count_d = '0;
            cause_d = FC_NONE;
          end
        end
        default: state_d = OccClear;
      endcase

      // Stuck checks rank below every counting fault raised above.
      if (fault == FC_NONE && state_q != OccFault) begin
        if (app_level[j] && stuck_app_q == STUCK_CYCLES - 24'd1) begin
          fault = FC_STUCK_APPROACH;
        end else if (exit_level[j] && stuck_exit_q == STUCK_CYCLES - 24'd1) begin
          fault = FC_STUCK_EXIT;
        end
      end

      if (fault != FC_NONE) begin
        state_d = OccFault;
        count_d = count_q;
        cause_d = fault;
      end
    end

    // Pulses come only from the two ordinary transitions, never from fault entry or clear.
    always_comb begin
      det_d    = (state_q == OccClear) && (state_d == OccOccupied);
      exited_d = (state_q == OccOccupied) && (state_d == OccClear);
    end

    assign train_detected[j]                        = det_q;
    assign train_exited[j]                          = exited_q;
    assign sensor_health[j]                         = (state_q != OccFault);
    assign occ_states[j*STATE_W +: STATE_W]         = state_q;
    assign axle_counts[j*AXLE_CNT_W +: AXLE_CNT_W]  = count_q;
    assign fault_causes[j*CAUSE_W +: CAUSE_W]       = cause_q;
  end

endmodule

// File: tb/tb_train_sensor_frontend.sv
// Directed bench for train_sensor_frontend: vector table plus hand-written multi-cycle sequences.
module tb_train_sensor_frontend;

  localparam int unsigned NC = 4;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [NC-1:0] approach_raw, exit_raw, fault_clear;
  logic [NC-1:0] train_detected, train_exited, sensor_health;
  logic [2*NC-1:0]  occ_states;
  logic [CW*NC-1:0] axle_counts;
  logic [3*NC-1:0]  fault_causes;

  int n_vec = 0;
  int n_bad = 0;
  logic [3:0] det_cnt  [NC] = '{default: '0};
  logic [3:0] exit_cnt [NC] = '{default: '0};

  always #5 clk = ~clk;

  train_sensor_frontend #(
    .NUM_CROSSINGS  (NC),
    .DEBOUNCE_CYCLES(4),
    .AXLE_CNT_W     (CW),
    .TIMEOUT_CYCLES (24'd200),
    .STUCK_CYCLES   (24'd100)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .approach_raw  (approach_raw),
    .exit_raw      (exit_raw),
    .fault_clear   (fault_clear),
    .train_detected(train_detected),
    .train_exited  (train_exited),
    .sensor_health (sensor_health),
    .occ_states    (occ_states),
    .axle_counts   (axle_counts),
    .fault_causes  (fault_causes)
  );

  // Pulse tally; a one-cycle pulse adds exactly one per event.
  always @(negedge clk) begin
    if (!rst) begin
      for (int j = 0; j < NC; j++) begin
        if (train_detected[j]) det_cnt[j] <= det_cnt[j] + 4'd1;
        if (train_exited[j])   exit_cnt[j] <= exit_cnt[j] + 4'd1;
        if (train_detected[j] && train_exited[j]) begin
          n_bad = n_bad + 1;
          $display("FAIL pulse_overlap crossing %0d: both pulses high, required at most one", j);
        end
      end
    end
  end

  typedef struct {
    logic [3:0]  app;
    logic [3:0]  ex;
    logic [3:0]  clr;
    int          cyc;
    logic [7:0]  occ;
    logic [31:0] cnt;
    logic [11:0] cause;
    logic [3:0]  health;
    logic [15:0] det;
    logic [15:0] exi;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(input logic [3:0] app, input logic [3:0] ex, input logic [3:0] clr,
                              input int cyc, input logic [7:0] occ, input logic [31:0] cnt,
                              input logic [11:0] cause, input logic [3:0] health,
                              input logic [15:0] det, input logic [15:0] exi);
    vec_t v;
    v.app = app; v.ex = ex; v.clr = clr; v.cyc = cyc; v.occ = occ; v.cnt = cnt;
    v.cause = cause; v.health = health; v.det = det; v.exi = exi;
    return v;
  endfunction

  function automatic logic [15:0] det_pack();
    return {det_cnt[3], det_cnt[2], det_cnt[1], det_cnt[0]};
  endfunction

  function automatic logic [15:0] exit_pack();
    return {exit_cnt[3], exit_cnt[2], exit_cnt[1], exit_cnt[0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [7:0] occ, input logic [31:0] cnt,
                           input logic [11:0] cause, input logic [3:0] health,
                           input logic [15:0] det, input logic [15:0] exi);
    check({name, ".occ"},    occ_states,    occ);
    check({name, ".cnt"},    axle_counts,   cnt);
    check({name, ".cause"},  fault_causes,  cause);
    check({name, ".health"}, sensor_health, health);
    check({name, ".det"},    det_pack(),    det);
    check({name, ".exi"},    exit_pack(),   exi);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Row order: rest of the normal pass, glitch on crossing 1, underflow and clear on crossing 2.
    tbl[0]  = mk(4'h0, 4'h0, 4'h0, 10, 8'h01, 32'h0000_0001, 12'h000, 4'hf, 16'h0001, 16'h0000);
    tbl[1]  = mk(4'h1, 4'h0, 4'h0, 10, 8'h01, 32'h0000_0002, 12'h000, 4'hf, 16'h0001, 16'h0000);
    tbl[2]  = mk(4'h0, 4'h0, 4'h0, 10, 8'h01, 32'h0000_0002, 12'h000, 4'hf, 16'h0001, 16'h0000);
    tbl[3]  = mk(4'h1, 4'h0, 4'h0, 10, 8'h01, 32'h0000_0003, 12'h000, 4'hf, 16'h0001, 16'h0000);
    tbl[4]  = mk(4'h0, 4'h0, 4'h0, 10, 8'h01, 32'h0000_0003, 12'h000, 4'hf, 16'h0001, 16'h0000);
    tbl[5]  = mk(4'h0, 4'h1, 4'h0, 10, 8'h01, 32'h0000_0002, 12'h000, 4'hf, 16'h0001, 16'h0000);
    tbl[6]  = mk(4'h0, 4'h0, 4'h0, 10, 8'h01, 32'h0000_0002, 12'h000, 4'hf, 16'h0001, 16'h0000);
    tbl[7]  = mk(4'h0, 4'h1, 4'h0, 10, 8'h01, 32'h0000_0001, 12'h000, 4'hf, 16'h0001, 16'h0000);
    tbl[8]  = mk(4'h0, 4'h0, 4'h0, 10, 8'h01, 32'h0000_0001, 12'h000, 4'hf, 16'h0001, 16'h0000);
    tbl[9]  = mk(4'h0, 4'h1, 4'h0, 10, 8'h00, 32'h0000_0000, 12'h000, 4'hf, 16'h0001, 16'h0001);
    tbl[10] = mk(4'h0, 4'h0, 4'h0, 10, 8'h00, 32'h0000_0000, 12'h000, 4'hf, 16'h0001, 16'h0001);
    tbl[11] = mk(4'h2, 4'h0, 4'h0,  3, 8'h00, 32'h0000_0000, 12'h000, 4'hf, 16'h0001, 16'h0001);
    tbl[12] = mk(4'h0, 4'h0, 4'h0, 10, 8'h00, 32'h0000_0000, 12'h000, 4'hf, 16'h0001, 16'h0001);
    tbl[13] = mk(4'h0, 4'h4, 4'h0, 10, 8'h20, 32'h0000_0000, 12'h040, 4'hb, 16'h0001, 16'h0001);
    tbl[14] = mk(4'h0, 4'h0, 4'h0, 10, 8'h20, 32'h0000_0000, 12'h040, 4'hb, 16'h0001, 16'h0001);
    tbl[15] = mk(4'h0, 4'h0, 4'h4,  1, 8'h00, 32'h0000_0000, 12'h000, 4'hf, 16'h0001, 16'h0001);
    tbl[16] = mk(4'h0, 4'h0, 4'h0,  2, 8'h00, 32'h0000_0000, 12'h000, 4'hf, 16'h0001, 16'h0001);

    rst          = 1'b1;
    approach_raw = '0;
    exit_raw     = '0;
    fault_clear  = '0;
    #1;
    check_all("reset", 8'h00, 32'h0, 12'h000, 4'hf, 16'h0, 16'h0);
    check("reset.pulses", {train_detected, train_exited}, 8'h00);
    step(3);
    rst = 1'b0;
    step(1);
    check_all("post_reset", 8'h00, 32'h0, 12'h000, 4'hf, 16'h0, 16'h0);

    // First approach axle on crossing 0: pulse exactly in cycle 3+DEBOUNCE_CYCLES = 7.
    approach_raw = 4'h1;
    step(6);
    check("lat.cyc6.det", train_detected, 4'h0);
    check("lat.cyc6.occ", occ_states, 8'h00);
    step(1);
    check("lat.cyc7.det", train_detected, 4'h1);
    check("lat.cyc7.cnt", axle_counts, 32'h1);
    check("lat.cyc7.occ", occ_states, 8'h01);
    step(1);
    check("lat.cyc8.det", train_detected, 4'h0);
    step(2);

    for (int i = 0; i < 17; i++) begin
      approach_raw = tbl[i].app;
      exit_raw     = tbl[i].ex;
      fault_clear  = tbl[i].clr;
      step(tbl[i].cyc);
      check_all($sformatf("row%0d", i), tbl[i].occ, tbl[i].cnt, tbl[i].cause, tbl[i].health,
                tbl[i].det, tbl[i].exi);
    end

    // Timeout on crossing 1: detect at cycle 7, no further edges, fault at 7+200.
    approach_raw = 4'h2;
    step(10);
    approach_raw = 4'h0;
    step(196);
    check("tmo.cyc206.occ", occ_states, 8'h04);
    step(1);
    check("tmo.cyc207.occ", occ_states, 8'h08);
    check("tmo.cyc207.cause", fault_causes, 12'h018);
    check("tmo.cyc207.health", sensor_health, 4'hd);
    step(1);
    check("tmo.no_exit", exit_pack(), 16'h0001);
    fault_clear = 4'h2;
    step(1);
    check_all("tmo.clear", 8'h00, 32'h0, 12'h000, 4'hf, 16'h0011, 16'h0001);
    fault_clear = 4'h0;
    step(1);

    // Stuck approach on crossing 1: debounced high at cycle 6, fault at 6+100.
    approach_raw = 4'h2;
    step(105);
    check("stk.cyc105.occ", occ_states, 8'h04);
    step(1);
    check("stk.cyc106.occ", occ_states, 8'h08);
    check("stk.cyc106.cause", fault_causes, 12'h020);
    fault_clear = 4'h2;
    step(1);
    check("stk.clear_ignored", occ_states, 8'h08);
    fault_clear  = 4'h0;
    approach_raw = 4'h0;
    step(12);
    fault_clear = 4'h2;
    step(1);
    check_all("stk.clear", 8'h00, 32'h0, 12'h000, 4'hf, 16'h0021, 16'h0001);
    fault_clear = 4'h0;
    step(1);

    // Crossing 0 to count 2 with crossing 3 entering alongside.
    approach_raw = 4'h9;
    step(10);
    approach_raw = 4'h0;
    step(10);
    approach_raw = 4'h1;
    step(10);
    approach_raw = 4'h0;
    step(10);
    check_all("iso.setup", 8'h41, 32'h0100_0002, 12'h000, 4'hf, 16'h1022, 16'h0001);

    // Coincident edges on crossing 0 while crossing 3 sees its last exit.
    approach_raw = 4'h1;
    exit_raw     = 4'h9;
    step(10);
    approach_raw = 4'h0;
    exit_raw     = 4'h0;
    step(10);
    check_all("iso.simul", 8'h01, 32'h0000_0002, 12'h000, 4'hf, 16'h1022, 16'h1001);

    // Reset mid-axle clears everything at once and nothing pulses after release.
    approach_raw = 4'h1;
    step(5);
    rst = 1'b1;
    #1;
    check_all("midrst", 8'h00, 32'h0, 12'h000, 4'hf, 16'h1022, 16'h1001);
    check("midrst.pulses", {train_detected, train_exited}, 8'h00);
    approach_raw = 4'h0;
    step(2);
    rst = 1'b0;
    step(12);
    check_all("midrst.after", 8'h00, 32'h0, 12'h000, 4'hf, 16'h1022, 16'h1001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
